// File: rtl/func_bist_if.sv
// Handshake bus between the BIST sequencer (master) and the func datapath (slave).
interface func_bist_if;
  logic [7:0] func_a_bo;
  logic [7:0] func_b_bo;
  logic       func_start_o;
  logic [1:0] func_busy_bi;
  logic [4:0] func_y_bi;

  modport master (output func_a_bo, func_b_bo, func_start_o,
                  input  func_busy_bi, func_y_bi);
  modport slave  (input  func_a_bo, func_b_bo, func_start_o,
                  output func_busy_bi, func_y_bi);
endinterface

// File: rtl/func_bist.sv
// BIST sequencer for func: LFSR operand stream, CRC-8 signature of results, pass/fail report.
// Optional wait-state watchdog enabled by defining FUNC_BIST_TIMEOUT_EN.
module func_bist #(
  parameter int          N_VECTORS   = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [7:0]  GOLDEN_SIG  = 8'h00,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        test_start_i,
  input  logic [7:0]  sw_a_bi,
  input  logic [7:0]  sw_b_bi,
  input  logic        sw_start_i,
  func_bist_if.master func_if,
  output logic        is_test_now_o,
  output logic        test_busy_o,
  output logic        test_pass_o,
  output logic        test_fail_o,
  output logic [8:0]  vec_cnt_bo,
  output logic [7:0]  sig_bo
);

  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [8:0]  N_LAST = 9'(N_VECTORS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ACCUM, S_CHECK
  } state_e;

  // CRC-8, poly 0x07, MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [4:0]  y_q, y_d;
  logic [7:0]  sig_q, sig_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;

`ifdef FUNC_BIST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first so no path infers a latch.
    state_d = state_q;
    lfsr_d  = lfsr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    y_d     = y_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
`ifdef FUNC_BIST_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    unique case (state_q)
      S_IDLE: if (test_start_i) begin
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        sig_d   = '0;
        cnt_d   = '0;
        lfsr_d  = SEED;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        op_a_d  = lfsr_q[15:8];
        op_b_d  = lfsr_q[7:0];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
`ifdef FUNC_BIST_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT_BUSY: begin
        if (func_if.func_busy_bi != 2'b00) begin
          state_d = S_WAIT_DONE;
`ifdef FUNC_BIST_TIMEOUT_EN
          wd_d    = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYC)) begin
          pass_d  = 1'b0;
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d    = wd_q + 1'b1;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (func_if.func_busy_bi == 2'b00) begin
          y_d     = func_if.func_y_bi;
          state_d = S_ACCUM;
`ifdef FUNC_BIST_TIMEOUT_EN
        end else if (wd_q == WD_W'(TIMEOUT_CYC)) begin
          pass_d  = 1'b0;
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d    = wd_q + 1'b1;
`endif
        end
      end
      S_ACCUM: begin
        sig_d   = crc8_step(sig_q, {3'b000, y_q});
        cnt_d   = cnt_q + 9'd1;
        lfsr_d  = lfsr_step(lfsr_q);
        state_d = (cnt_q + 9'd1 == N_LAST) ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
        pass_d  = (sig_q == GOLDEN_SIG);
        fail_d  = (sig_q != GOLDEN_SIG);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      op_a_q  <= '0;
      op_b_q  <= '0;
      y_q     <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef FUNC_BIST_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      y_q     <= y_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`ifdef FUNC_BIST_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  // Manual mode is a pure pass-through; test mode drives the latched operands.
  assign func_if.func_a_bo    = (state_q == S_IDLE) ? sw_a_bi : op_a_q;
  assign func_if.func_b_bo    = (state_q == S_IDLE) ? sw_b_bi : op_b_q;
  assign func_if.func_start_o = (state_q == S_IDLE) ? sw_start_i : (state_q == S_ISSUE);

  assign is_test_now_o = (state_q != S_IDLE);
  assign test_busy_o   = (state_q != S_IDLE);
  assign test_pass_o   = pass_q;
  assign test_fail_o   = fail_q;
  assign vec_cnt_bo    = cnt_q;
  assign sig_bo        = sig_q;

endmodule

// File: tb/tb_func_bist.sv
// Self-checking bench for func_bist: three instances (default run, 1-vector pass, 1-vector fail).
module tb_func_bist;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic [7:0]    sw_a, sw_b;
  logic          sw_start;
  logic [NI-1:0] test_start;
  logic          stuck;

  logic [7:0]    fa [NI];
  logic [7:0]    fb [NI];
  logic [8:0]    vcnt [NI];
  logic [7:0]    sig [NI];
  logic [NI-1:0] fst, itn, tbusy, tpass, tfail;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference model, arithmetic form.
  function automatic logic [15:0] m_lfsr_next(input logic [15:0] x);
    int v, fb_bit;
    v = int'(x);
    fb_bit = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (fb_bit << 15));
  endfunction

  function automatic logic [7:0] m_crc8(input logic [7:0] crc, input logic [7:0] data);
    int r;
    r = int'(crc ^ data) << 8;
    for (int i = 15; i >= 8; i--)
      if (((r >> i) & 1) == 1) r = r ^ (32'h107 << (i - 8));
    return 8'(r);
  endfunction

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int icbrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic logic [4:0] func_ref(input logic [7:0] a, input logic [7:0] b);
    return 5'(isqrt(int'(a) + icbrt(int'(b))));
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int          NV = (g == 0) ? 256 : 1;
    localparam logic [15:0] SD = (g == 0) ? 16'hACE1 : 16'h0300;
    localparam logic [7:0]  GS = (g == 1) ? 8'h07 : 8'h00;

    func_bist_if bus ();

    func_bist #(
      .N_VECTORS  (NV),
      .LFSR_SEED  (SD),
      .GOLDEN_SIG (GS),
      .TIMEOUT_CYC(20)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .test_start_i (test_start[g]),
      .sw_a_bi      (sw_a),
      .sw_b_bi      (sw_b),
      .sw_start_i   (sw_start),
      .func_if      (bus),
      .is_test_now_o(itn[g]),
      .test_busy_o  (tbusy[g]),
      .test_pass_o  (tpass[g]),
      .test_fail_o  (tfail[g]),
      .vec_cnt_bo   (vcnt[g]),
      .sig_bo       (sig[g])
    );

    // Behavioural func: busy from the cycle after start for 1..4 cycles, result held.
    int         lat_left = 0;
    logic [4:0] y_r = 5'd0;
    always @(posedge clk) begin
      if (bus.func_start_o) begin
        lat_left <= 1 + int'(bus.func_a_bo[1:0]);
        y_r      <= func_ref(bus.func_a_bo, bus.func_b_bo);
      end else if (lat_left > 0) begin
        lat_left <= lat_left - 1;
      end
    end
    assign bus.func_busy_bi = ((stuck && (g == 0)) || lat_left != 0) ? 2'b01 : 2'b00;
    assign bus.func_y_bi    = y_r;
    assign fa[g]  = bus.func_a_bo;
    assign fb[g]  = bus.func_b_bo;
    assign fst[g] = bus.func_start_o;
  end

  // Compare process for instance 0: passthrough in manual mode, operand stream and signature in test mode.
  logic [15:0] m_lfsr   = 16'hACE1;
  logic [7:0]  m_sig    = 8'h00;
  int          m_starts = 0;
  logic        prev_start = 1'b0;

  always @(negedge clk) begin
    if (!rst_i) begin
      prev_start <= 1'b0;
    end else begin
      check("busy_eq_test_now", 32'(tbusy[0]), 32'(itn[0]));
      if (!itn[0]) begin
        check("idle_a_passthru", 32'(fa[0]), 32'(sw_a));
        check("idle_b_passthru", 32'(fb[0]), 32'(sw_b));
        check("idle_start_passthru", 32'(fst[0]), 32'(sw_start));
        if (test_start[0]) begin
          m_lfsr   <= 16'hACE1;
          m_sig    <= 8'h00;
          m_starts <= 0;
        end
      end else if (fst[0]) begin
        check("start_single_cycle", 32'(prev_start), 32'd0);
        check("vec_a", 32'(fa[0]), 32'(m_lfsr[15:8]));
        check("vec_b", 32'(fb[0]), 32'(m_lfsr[7:0]));
        m_sig    <= m_crc8(m_sig, {3'b000, func_ref(m_lfsr[15:8], m_lfsr[7:0])});
        m_lfsr   <= m_lfsr_next(m_lfsr);
        m_starts <= m_starts + 1;
      end
      prev_start <= fst[0] && itn[0];
    end
  end

  task automatic pulse_start(input logic [NI-1:0] which);
    @(posedge clk); #1 test_start = which;
    @(posedge clk); #1 test_start = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(fst[0]), 32'd0);
    check({tag, "_test_now"}, 32'(itn[0]), 32'd0);
    check({tag, "_busy"}, 32'(tbusy[0]), 32'd0);
    check({tag, "_pass"}, 32'(tpass[0]), 32'd0);
    check({tag, "_fail"}, 32'(tfail[0]), 32'd0);
    check({tag, "_vec_cnt"}, 32'(vcnt[0]), 32'd0);
    check({tag, "_sig"}, 32'(sig[0]), 32'd0);
    check({tag, "_a_follows_sw"}, 32'(fa[0]), 32'h5A);
  endtask

  // Waits for instance 0 to leave test mode, with optional mid-run disturbance.
  task automatic wait_run_end(input int budget, input bit disturb, output int cycles);
    bit disturbed = 1'b0;
    cycles = 0;
    while (itn[0] && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (disturb && !disturbed && m_starts >= 100) begin
        disturbed = 1'b1;
        @(posedge clk); #1 test_start[0] = 1'b1; sw_start = 1'b1;
        @(posedge clk); #1 test_start[0] = 1'b0; sw_start = 1'b0;
      end
    end
    if (itn[0]) fail_bound("run_end");
  endtask

  task automatic check_full_run(input string tag);
    check({tag, "_starts"}, 32'(m_starts), 32'd256);
    check({tag, "_sig"}, 32'(sig[0]), 32'(m_sig));
    check({tag, "_vec_cnt"}, 32'(vcnt[0]), 32'd256);
    check({tag, "_pass"}, 32'(tpass[0]), 32'(m_sig == 8'h00));
    check({tag, "_fail"}, 32'(tfail[0]), 32'(m_sig != 8'h00));
    check({tag, "_test_now"}, 32'(itn[0]), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_i = 1'b0; sw_a = 8'h5A; sw_b = 8'h00; sw_start = 1'b0;
    test_start = '0; stuck = 1'b0;

    // Pin the reference model with hand-computed values.
    check("pin_lfsr_ace1", 32'(m_lfsr_next(16'hACE1)), 32'h5670);
    check("pin_crc_01", 32'(m_crc8(8'h00, 8'h01)), 32'h07);
    check("pin_func_3_0", 32'(func_ref(8'd3, 8'd0)), 32'd1);
    check("pin_func_16_0", 32'(func_ref(8'd16, 8'd0)), 32'd4);
    check("pin_func_0_27", 32'(func_ref(8'd0, 8'd27)), 32'd1);
    check("pin_func_255_216", 32'(func_ref(8'd255, 8'd216)), 32'd16);

    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk); #1 rst_i = 1'b1;

    // Manual mode.
    @(posedge clk); #1 sw_a = 8'd16; sw_b = 8'd0; sw_start = 1'b1;
    @(negedge clk);
    check("manual_a", 32'(fa[0]), 32'd16);
    check("manual_b", 32'(fb[0]), 32'd0);
    check("manual_start_hi", 32'(fst[0]), 32'd1);
    check("manual_test_now", 32'(itn[0]), 32'd0);
    @(posedge clk); #1 sw_start = 1'b0;
    @(negedge clk);
    check("manual_start_lo", 32'(fst[0]), 32'd0);

    // One-vector runs: seed 0300 -> a=3, b=0, y=1, sig=07.
    pulse_start(3'b110);
    cyc = 0;
    while (!fst[1] && cyc < 20) begin @(negedge clk); cyc++; end
    if (!fst[1]) fail_bound("one_vec_issue");
    check("one_vec_a", 32'(fa[1]), 32'd3);
    check("one_vec_b", 32'(fb[1]), 32'd0);
    cyc = 0;
    while ((itn[1] || itn[2]) && cyc < 50) begin @(negedge clk); cyc++; end
    if (itn[1] || itn[2]) fail_bound("one_vec_end");
    check("golden07_pass", 32'(tpass[1]), 32'd1);
    check("golden07_fail", 32'(tfail[1]), 32'd0);
    check("golden07_sig", 32'(sig[1]), 32'h07);
    check("golden07_cnt", 32'(vcnt[1]), 32'd1);
    check("golden00_pass", 32'(tpass[2]), 32'd0);
    check("golden00_fail", 32'(tfail[2]), 32'd1);
    check("golden00_sig", 32'(sig[2]), 32'h07);

    // Full 256-vector run with ignored test_start / sw_start pulses mid-run.
    sw_a = 8'h5A;
    pulse_start(3'b001);
    wait_run_end(5000, 1'b1, cyc);
    check_full_run("full1");

    // Reset during vector 10, then a fresh full run.
    pulse_start(3'b001);
    cyc = 0;
    while (m_starts < 10 && cyc < 200) begin @(negedge clk); cyc++; end
    if (m_starts < 10) fail_bound("reach_vec10");
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst_i = 1'b1;
    pulse_start(3'b001);
    wait_run_end(5000, 1'b0, cyc);
    check_full_run("full2");

`ifdef FUNC_BIST_TIMEOUT_EN
    // Watchdog: busy stuck high aborts with fail.
    stuck = 1'b1;
    pulse_start(3'b001);
    wait_run_end(200, 1'b0, cyc);
    check("wd_fail", 32'(tfail[0]), 32'd1);
    check("wd_pass", 32'(tpass[0]), 32'd0);
    check("wd_test_now", 32'(itn[0]), 32'd0);
    check("wd_vec_cnt", 32'(vcnt[0]), 32'd0);
    check("wd_window", 32'(cyc >= 18 && cyc <= 30), 32'd1);
    stuck = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
